// File: rtl/uart_ctrl.sv
// UART controller: baud tick generator, TX/RX engines and FIFOs. Define
// UART_CTRL_LOOPBACK_EN to add the `loopback` input (internal TX->RX path).
//   state    | meaning (shared by TX and RX engines)
//   S_IDLE   | line idle, waiting for start edge (RX) or FIFO data (TX)
//   S_START  | start bit
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when parity enabled)
//   S_STOP   | stop bit(s)

module uart_ctrl_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [W-1:0]     din,
   input  logic             rd_en,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LVL_W-1:0] cnt_q;
   logic             wr_ok, rd_ok;

   assign full  = (cnt_q == LVL_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign level = cnt_q;
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;
   assign dout  = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) wptr_q <= wptr_q + 1'b1;
         if (rd_ok) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q] <= din;
   end
endmodule

module uart_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           par_mode,
   input  logic                 stop2,
   input  logic                 rx,
`ifdef UART_CTRL_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic                 tx,
   input  logic                 tx_wr_en,
   input  logic [DATA_BITS-1:0] tx_din,
   output logic                 tx_full,
   output logic [LVL_W-1:0]     tx_level,
   output logic                 tx_busy,
   input  logic                 rx_rd_en,
   output logic [DATA_BITS-1:0] rx_dout,
   output logic                 rx_empty,
   output logic [LVL_W-1:0]     rx_level,
   input  logic [LVL_W-1:0]     rx_thresh,
   output logic                 rx_irq,
   input  logic                 err_clr,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic             tick;

   assign tick = (div_cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst || tick) div_cnt_q <= baud_div;
      else             div_cnt_q <= div_cnt_q - 1'b1;
   end

   logic tx_ser, rx_src, rx_s1_q, rx_s2_q, rx_prev_q;

`ifdef UART_CTRL_LOOPBACK_EN
   assign rx_src = loopback ? tx_ser : rx;
   assign tx     = loopback ? 1'b1 : tx_ser;
`else
   assign rx_src = rx;
   assign tx     = tx_ser;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx_src;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // ---------------- TX engine ----------------
   state_t                tx_state_q, tx_state_d;
   logic [4:0]            tx_tcnt_q, tx_tcnt_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]  tx_sh_q, tx_sh_d, tx_fifo_dout;
   logic                  tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
   logic                  tx_stop2_q, tx_stop2_d;
   logic                  tx_empty, tx_pop, tx_bit_end;

   uart_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
      .clk(clk), .rst(rst), .wr_en(tx_wr_en), .din(tx_din), .rd_en(tx_pop),
      .dout(tx_fifo_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );

   assign tx_bit_end = tick &&
      (tx_tcnt_q == ((tx_state_q == S_STOP && tx_stop2_q) ? 5'd31 : 5'd15));

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_tcnt_d    = tx_tcnt_q;
      tx_bit_d     = tx_bit_q;
      tx_sh_d      = tx_sh_q;
      tx_par_en_d  = tx_par_en_q;
      tx_par_bit_d = tx_par_bit_q;
      tx_stop2_d   = tx_stop2_q;
      tx_pop       = 1'b0;
      if (tx_state_q != S_IDLE && tick)
         tx_tcnt_d = tx_bit_end ? 5'd0 : tx_tcnt_q + 5'd1;
      case (tx_state_q)
         S_IDLE:   tx_pop = ~tx_empty;
         S_START:  if (tx_bit_end) begin
                      tx_bit_d   = '0;
                      tx_state_d = S_DATA;
                   end
         S_DATA:   if (tx_bit_end) begin
                      tx_sh_d  = tx_sh_q >> 1;
                      tx_bit_d = tx_bit_q + 4'd1;
                      if (tx_bit_q == BIT_LAST) tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
                   end
         S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
         S_STOP:   if (tx_bit_end) begin
                      tx_state_d = S_IDLE;
                      tx_pop     = ~tx_empty;
                   end
         default:  tx_state_d = S_IDLE;
      endcase
      // Next frame starts straight out of the stop bit so queued bytes go back-to-back.
      if (tx_pop) begin
         tx_state_d   = S_START;
         tx_tcnt_d    = '0;
         tx_sh_d      = tx_fifo_dout;
         tx_par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
         tx_par_bit_d = (^tx_fifo_dout) ^ (par_mode == 2'b10);
         tx_stop2_d   = stop2;
      end
   end

   always_comb begin
      tx_ser = 1'b1;
      case (tx_state_q)
         S_START:  tx_ser = 1'b0;
         S_DATA:   tx_ser = tx_sh_q[0];
         S_PARITY: tx_ser = tx_par_bit_q;
         default:  tx_ser = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q   <= S_IDLE;
         tx_tcnt_q    <= '0;
         tx_bit_q     <= '0;
         tx_sh_q      <= '0;
         tx_par_en_q  <= 1'b0;
         tx_par_bit_q <= 1'b0;
         tx_stop2_q   <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_tcnt_q    <= tx_tcnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_sh_q      <= tx_sh_d;
         tx_par_en_q  <= tx_par_en_d;
         tx_par_bit_q <= tx_par_bit_d;
         tx_stop2_q   <= tx_stop2_d;
      end
   end

   // ---------------- RX engine ----------------
   state_t               rx_state_q, rx_state_d;
   logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
   logic                 rx_par_bit_q, rx_par_bit_d;
   logic                 rx_push, rx_full, set_perr, set_ferr, set_oerr;
   logic                 perr_q, ferr_q, oerr_q;

   uart_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
      .clk(clk), .rst(rst), .wr_en(rx_push), .din(rx_sh_q), .rd_en(rx_rd_en),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_tcnt_d    = rx_tcnt_q;
      rx_bit_d     = rx_bit_q;
      rx_sh_d      = rx_sh_q;
      rx_par_en_d  = rx_par_en_q;
      rx_par_odd_d = rx_par_odd_q;
      rx_par_bit_d = rx_par_bit_q;
      rx_push      = 1'b0;
      set_perr     = 1'b0;
      set_ferr     = 1'b0;
      set_oerr     = 1'b0;
      if (rx_state_q != S_IDLE && tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
      case (rx_state_q)
         S_IDLE:   if (rx_prev_q && !rx_s2_q) begin
                      rx_state_d = S_START;
                      rx_tcnt_d  = '0;
                   end
         S_START:  if (tick && rx_tcnt_q == 4'd7) begin
                      rx_tcnt_d    = '0;
                      rx_bit_d     = '0;
                      rx_state_d   = rx_s2_q ? S_IDLE : S_DATA;
                      rx_par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
                      rx_par_odd_d = (par_mode == 2'b10);
                   end
         S_DATA:   if (tick && rx_tcnt_q == 4'd15) begin
                      rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                      rx_bit_d = rx_bit_q + 4'd1;
                      if (rx_bit_q == BIT_LAST) rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
                   end
         S_PARITY: if (tick && rx_tcnt_q == 4'd15) begin
                      rx_par_bit_d = rx_s2_q;
                      rx_state_d   = S_STOP;
                   end
         S_STOP:   if (tick && rx_tcnt_q == 4'd15) begin
                      rx_state_d = S_IDLE;
                      set_ferr   = ~rx_s2_q;
                      set_perr   = rx_par_en_q && (rx_par_bit_q != ((^rx_sh_q) ^ rx_par_odd_q));
                      if (!set_ferr && !set_perr) begin
                         set_oerr = rx_full;
                         rx_push  = ~rx_full;
                      end
                   end
         default:  rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q   <= S_IDLE;
         rx_tcnt_q    <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_par_bit_q <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         oerr_q       <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_tcnt_q    <= rx_tcnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_par_odd_q <= rx_par_odd_d;
         rx_par_bit_q <= rx_par_bit_d;
         perr_q       <= set_perr | (perr_q & ~err_clr);
         ferr_q       <= set_ferr | (ferr_q & ~err_clr);
         oerr_q       <= set_oerr | (oerr_q & ~err_clr);
      end
   end

   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;
   assign rx_irq      = (rx_thresh != '0) && (rx_level >= rx_thresh);
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: TX bit stream, RX errors, FIFO levels, IRQ, reset.
`timescale 1ns/1ps
module tb_uart_ctrl;
   localparam int DW = 8;
   localparam int LVL_W = 5;
   localparam int BIT_CLK = 64;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] baud_div;
   logic [1:0] par_mode;
   logic stop2, rx, tx, tx_wr_en, tx_full, tx_busy, rx_rd_en, rx_empty, rx_irq;
   logic err_clr, parity_err, frame_err, overrun_err;
   logic [DW-1:0] tx_din, rx_dout;
   logic [LVL_W-1:0] tx_level, rx_level, rx_thresh;
`ifdef UART_CTRL_LOOPBACK_EN
   logic loopback = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] rx_exp_q[$];
   logic tx_exp_q[$];

   uart_ctrl dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .par_mode(par_mode), .stop2(stop2),
      .rx(rx),
`ifdef UART_CTRL_LOOPBACK_EN
      .loopback(loopback),
`endif
      .tx(tx), .tx_wr_en(tx_wr_en), .tx_din(tx_din), .tx_full(tx_full),
      .tx_level(tx_level), .tx_busy(tx_busy), .rx_rd_en(rx_rd_en), .rx_dout(rx_dout),
      .rx_empty(rx_empty), .rx_level(rx_level), .rx_thresh(rx_thresh), .rx_irq(rx_irq),
      .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
      .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic s2);
      tx_exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) tx_exp_q.push_back(d[i]);
      if (pm == 2'b01 || pm == 2'b10) tx_exp_q.push_back((^d) ^ (pm == 2'b10));
      tx_exp_q.push_back(1'b1);
      if (s2) tx_exp_q.push_back(1'b1);
   endtask

   // Called on the first cycle of a start bit; samples mid-slot and measures busy length.
   task automatic tx_capture(input int max_cycles, output int busy_len);
      int c = 0;
      logic e;
      while (tx_busy === 1'b1 && c < max_cycles) begin
         if (tx_exp_q.size() > 0 && (c == 30 || (c >= 92 && (c - 92) % BIT_CLK == 0))) begin
            e = tx_exp_q.pop_front();
            checks++;
            if (tx !== e) begin
               failures++;
               $display("FAIL tx_bit at cycle %0d: got %b expected %b", c, tx, e);
            end
         end
         c++;
         cyc(1);
      end
      busy_len = c;
      checks++;
      if (tx_exp_q.size() != 0 || c >= max_cycles) begin
         failures++;
         $display("FAIL tx_frame_done: %0d bits unsampled, cycles %0d", tx_exp_q.size(), c);
         tx_exp_q.delete();
      end
   endtask

   task automatic send_rx(input logic [DW-1:0] d, input logic [1:0] pm, input logic flip_par,
                          input logic stop_v);
      rx = 1'b0;
      cyc(BIT_CLK);
      for (int i = 0; i < DW; i++) begin
         rx = d[i];
         cyc(BIT_CLK);
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         rx = (^d) ^ (pm == 2'b10) ^ flip_par;
         cyc(BIT_CLK);
      end
      rx = stop_v;
      cyc(BIT_CLK);
      rx = 1'b1;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0 || tx_level !== '0) begin
         failures++;
         $display("FAIL reset_tx: tx=%b busy=%b full=%b level=%0d expected 1 0 0 0", tx, tx_busy, tx_full, tx_level);
      end
      checks++;
      if (rx_empty !== 1'b1 || rx_level !== '0 || rx_dout !== '0 || rx_irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_rx: empty=%b level=%0d dout=%h irq=%b expected 1 0 00 0", rx_empty, rx_level, rx_dout, rx_irq);
      end
      checks++;
      if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000", {parity_err, frame_err, overrun_err});
      end
      // 18 writes while the engine pops once: FIFO ends full at 16, last write ignored
      tx_wr_en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tx_din = DW'(8'h40 + i);
         cyc(1);
      end
      tx_wr_en = 1'b0;
      checks++;
      if (tx_full !== 1'b1 || tx_level !== LVL_W'(16)) begin
         failures++;
         $display("FAIL tx_full: full=%b level=%0d expected 1 16", tx_full, tx_level);
      end
      cyc(100);
      checks++;
      if (tx_busy !== 1'b1) begin
         failures++;
         $display("FAIL midframe_busy: got %b expected 1", tx_busy);
      end
      rst = 1'b1;
      cyc(1);
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL rst_tx_next: got %b expected 1", tx);
      end
      cyc(1);
      rst = 1'b0;
      checks++;
      if (tx_busy !== 1'b0 || tx_level !== '0 || tx_full !== 1'b0 || rx_empty !== 1'b1 || rx_level !== '0) begin
         failures++;
         $display("FAIL rst_flush: busy=%b txlvl=%0d full=%b rxempty=%b rxlvl=%0d expected 0 0 0 1 0", tx_busy, tx_level, tx_full, rx_empty, rx_level);
      end
      cyc(20);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_stay_idle: tx=%b busy=%b expected 1 0", tx, tx_busy);
      end
   endtask

   task automatic test_tx();
      int len;
      par_mode = 2'b01;
      stop2 = 1'b0;
      push_tx_frame(8'hA5, 2'b01, 1'b0);
      tx_din = 8'hA5;
      tx_wr_en = 1'b1;
      cyc(1);
      tx_wr_en = 1'b0;
      checks++;
      if (tx_level !== LVL_W'(1) || tx_busy !== 1'b0 || tx !== 1'b1) begin
         failures++;
         $display("FAIL tx_n1: level=%0d busy=%b tx=%b expected 1 0 1", tx_level, tx_busy, tx);
      end
      cyc(1);
      checks++;
      if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_level !== '0) begin
         failures++;
         $display("FAIL tx_n2: tx=%b busy=%b level=%0d expected 0 1 0", tx, tx_busy, tx_level);
      end
      tx_capture(2000, len);
      checks++;
      if (len < 701 || len > 704) begin
         failures++;
         $display("FAIL tx_busy_len: got %0d expected 701..704", len);
      end
   endtask

   task automatic test_back_to_back();
      int len;
      par_mode = 2'b00;
      stop2 = 1'b1;
      push_tx_frame(8'h3C, 2'b00, 1'b1);
      push_tx_frame(8'hC3, 2'b00, 1'b1);
      tx_wr_en = 1'b1;
      tx_din = 8'h3C;
      cyc(1);
      tx_din = 8'hC3;
      cyc(1);
      tx_wr_en = 1'b0;
      checks++;
      if (tx_busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_start: busy=%b expected 1", tx_busy);
      end
      tx_capture(4000, len);
      checks++;
      if (len < 1405 || len > 1408) begin
         failures++;
         $display("FAIL b2b_busy_len: got %0d expected 1405..1408", len);
      end
      stop2 = 1'b0;
   endtask

   task automatic test_rx_parity();
      par_mode = 2'b10;
      send_rx(8'h3C, 2'b10, 1'b1, 1'b1);
      checks++;
      if (parity_err !== 1'b1 || rx_empty !== 1'b1 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL rx_parity_err: perr=%b empty=%b ferr=%b expected 1 1 0", parity_err, rx_empty, frame_err);
      end
      pulse_err_clr();
      checks++;
      if (parity_err !== 1'b0) begin
         failures++;
         $display("FAIL parity_clr: got %b expected 0", parity_err);
      end
      rx_exp_q.push_back(8'h3C);
      send_rx(8'h3C, 2'b10, 1'b0, 1'b1);
      checks++;
      if (rx_empty !== 1'b0 || parity_err !== 1'b0 || rx_dout !== rx_exp_q[0]) begin
         failures++;
         $display("FAIL rx_parity_good: empty=%b perr=%b dout=%h expected 0 0 %h", rx_empty, parity_err, rx_dout, rx_exp_q[0]);
      end
      void'(rx_exp_q.pop_front());
      rx_rd_en = 1'b1;
      cyc(1);
      rx_rd_en = 1'b0;
   endtask

   task automatic test_rx_overrun();
      int lvl;
      logic [DW-1:0] e;
      par_mode = 2'b00;
      rx_thresh = LVL_W'(4);
      for (int k = 0; k < 17; k++) begin
         if (k < 16) rx_exp_q.push_back(DW'(k));
         send_rx(DW'(k), 2'b00, 1'b0, 1'b1);
         lvl = (k + 1 > 16) ? 16 : k + 1;
         checks++;
         if (rx_level !== LVL_W'(lvl) || rx_irq !== (k + 1 >= 4) || overrun_err !== (k == 16)) begin
            failures++;
            $display("FAIL rx_fill[%0d]: level=%0d irq=%b oerr=%b expected %0d %b %b", k, rx_level, rx_irq, overrun_err, lvl, (k + 1 >= 4), (k == 16));
         end
      end
      checks++;
      if (rx_dout !== 8'h00) begin
         failures++;
         $display("FAIL rx_head: got %h expected 00", rx_dout);
      end
      for (int i = 0; i < 20 && rx_exp_q.size() > 0; i++) begin
         e = rx_exp_q.pop_front();
         checks++;
         if (rx_empty !== 1'b0 || rx_dout !== e) begin
            failures++;
            $display("FAIL rx_drain[%0d]: empty=%b dout=%h expected 0 %h", i, rx_empty, rx_dout, e);
         end
         rx_rd_en = 1'b1;
         cyc(1);
         rx_rd_en = 1'b0;
      end
      checks++;
      if (rx_empty !== 1'b1 || rx_irq !== 1'b0) begin
         failures++;
         $display("FAIL rx_drained: empty=%b irq=%b expected 1 0", rx_empty, rx_irq);
      end
      pulse_err_clr();
      rx_thresh = '0;
   endtask

   task automatic test_rx_frame();
      send_rx(8'h55, 2'b00, 1'b0, 1'b0);
      cyc(BIT_CLK);
      checks++;
      if (frame_err !== 1'b1 || rx_empty !== 1'b1 || parity_err !== 1'b0) begin
         failures++;
         $display("FAIL rx_frame_err: ferr=%b empty=%b perr=%b expected 1 1 0", frame_err, rx_empty, parity_err);
      end
      pulse_err_clr();
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL frame_clr: got %b expected 0", frame_err);
      end
   endtask

   task automatic test_false_start();
      rx = 1'b0;
      cyc(16);
      rx = 1'b1;
      cyc(200);
      checks++;
      if (rx_empty !== 1'b1 || {parity_err, frame_err, overrun_err} !== 3'b000) begin
         failures++;
         $display("FAIL false_start: empty=%b flags=%b expected 1 000", rx_empty, {parity_err, frame_err, overrun_err});
      end
      rx_exp_q.push_back(8'h81);
      send_rx(8'h81, 2'b00, 1'b0, 1'b1);
      checks++;
      if (rx_empty !== 1'b0 || rx_dout !== rx_exp_q[0]) begin
         failures++;
         $display("FAIL after_false_start: empty=%b dout=%h expected 0 %h", rx_empty, rx_dout, rx_exp_q[0]);
      end
      void'(rx_exp_q.pop_front());
      rx_rd_en = 1'b1;
      cyc(1);
      rx_rd_en = 1'b0;
   endtask

`ifdef UART_CTRL_LOOPBACK_EN
   task automatic test_loopback();
      int c = 0;
      int tx_low = 0;
      loopback = 1'b1;
      par_mode = 2'b00;
      rx_exp_q.push_back(8'h5A);
      tx_din = 8'h5A;
      tx_wr_en = 1'b1;
      cyc(1);
      tx_wr_en = 1'b0;
      while (rx_empty === 1'b1 && c < 2000) begin
         if (tx !== 1'b1) tx_low++;
         c++;
         cyc(1);
      end
      checks++;
      if (c >= 2000 || rx_dout !== rx_exp_q[0]) begin
         failures++;
         $display("FAIL loopback_data: dout=%h cycles=%0d expected %h", rx_dout, c, rx_exp_q[0]);
      end
      void'(rx_exp_q.pop_front());
      rx_rd_en = 1'b1;
      c = 0;
      while (tx_busy === 1'b1 && c < 200) begin
         if (tx !== 1'b1) tx_low++;
         c++;
         cyc(1);
         rx_rd_en = 1'b0;
      end
      rx_rd_en = 1'b0;
      checks++;
      if (tx_low != 0 || tx_busy !== 1'b0) begin
         failures++;
         $display("FAIL loopback_pin: tx low %0d cycles, busy=%b expected 0 0", tx_low, tx_busy);
      end
      loopback = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      baud_div = 16'd3;
      par_mode = 2'b00;
      stop2 = 1'b0;
      rx = 1'b1;
      tx_wr_en = 1'b0;
      tx_din = '0;
      rx_rd_en = 1'b0;
      rx_thresh = '0;
      err_clr = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      test_reset();
      test_tx();
      test_back_to_back();
      test_rx_parity();
      test_rx_overrun();
      test_rx_frame();
      test_false_start();
`ifdef UART_CTRL_LOOPBACK_EN
      test_loopback();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
